alu_sequencer: RTL and testbench

Multi-cycle issue/writeback controller that drives the 16-bit ALU and consumes its result and flags. It accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 8×16 register file. It drives `a`/`b`/`op`/`en`/`setflag` into the ALU, captures `r`/`z`/`n`, and writes the result back. It sits between instruction decode and the ALU in the CPU datapath.

---
 rtl/alu_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Issue/writeback controller for the 16-bit ALU: accepts one instruction at a time,
// reads operands from an internal 8x16 register file, captures result/flags, writes back.
module alu_sequencer #(
    parameter int NREG = 8,
    parameter int W    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         instr_valid,
    input  logic [15:0]  instr,
    output logic         instr_ready,
    input  logic         ld_valid,
    input  logic [2:0]   ld_addr,
    input  logic [W-1:0] ld_data,
    input  logic [2:0]   rd_addr,
    output logic [W-1:0] rd_data,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_op,
    output logic         alu_en,
    output logic         alu_setflag,
    input  logic [W-1:0] alu_r,
    input  logic         alu_z,
    input  logic         alu_n,
    output logic         flag_z,
    output logic         flag_n,
    output logic         done,
    output logic         busy
);

    // state | meaning
    // IDLE  | ready for an instruction, ALU outputs idle
    // EXEC  | operands on the ALU; result and flags captured at the closing edge
    // WB    | done pulse; optional write of the captured result to reg[dst]
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t         r_state;
    logic [15:0]    r_ir;
    logic [W-1:0]   r_res;
    logic [W-1:0]   r_regs [NREG];
    logic           r_flag_z;
    logic           r_flag_n;
    logic           r_done;
    logic           r_busy;
    logic           r_ready;
    logic           r_alu_en;
    logic [2:0]     r_alu_op;
    logic           r_alu_setflag;

    logic           w_wb_we;
    logic [2:0]     w_dst;
    logic [2:0]     w_srca;
    logic [2:0]     w_srcb;
    logic           w_unused;

    assign w_dst    = r_ir[10:8];
    assign w_srca   = r_ir[7:5];
    assign w_srcb   = r_ir[4:2];
    assign w_wb_we  = (r_state == S_WB) && r_ir[11];
    assign w_unused = ^r_ir[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ir          <= '0;
            r_res         <= '0;
            r_flag_z      <= 1'b0;
            r_flag_n      <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
            r_ready       <= 1'b1;
            r_alu_en      <= 1'b0;
            r_alu_op      <= 3'b000;
            r_alu_setflag <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_ir          <= instr;
                        r_state       <= S_EXEC;
                        r_ready       <= 1'b0;
                        r_busy        <= 1'b1;
                        r_alu_en      <= 1'b1;
                        r_alu_op      <= instr[15:13];
                        r_alu_setflag <= instr[12];
                    end
                end
                S_EXEC: begin
                    r_res <= alu_r;
                    if (r_ir[12]) begin
                        r_flag_z <= alu_z;
                        r_flag_n <= alu_n;
                    end
                    r_state       <= S_WB;
                    r_done        <= 1'b1;
                    r_alu_en      <= 1'b0;
                    r_alu_op      <= 3'b000;
                    r_alu_setflag <= 1'b0;
                end
                S_WB: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Writeback takes priority over a preload to the same address on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_wb_we && (w_dst == 3'(i))) begin
                    r_regs[i] <= r_res;
                end else if (ld_valid && (ld_addr == 3'(i))) begin
                    r_regs[i] <= ld_data;
                end
            end
        end
    end

    // Operands are read live in EXEC so a preload on the accept edge is seen.
    assign alu_a       = r_alu_en ? r_regs[w_srca] : '0;
    assign alu_b       = r_alu_en ? r_regs[w_srcb] : '0;
    assign alu_op      = r_alu_op;
    assign alu_en      = r_alu_en;
    assign alu_setflag = r_alu_setflag;

    assign rd_data     = r_regs[rd_addr];
    assign flag_z      = r_flag_z;
    assign flag_n      = r_flag_n;
    assign done        = r_done;
    assign busy        = r_busy;
    assign instr_ready = r_ready;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU plus an instruction-level
// reference model of the register file and flags.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        ld_valid;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic [15:0] alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        alu_en, alu_setflag;
    logic [15:0] alu_r;
    logic        alu_z, alu_n;
    logic        flag_z, flag_n, done, busy;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [15:0] m_reg [8];
    logic        m_z, m_n;

    always #10 clk = ~clk;

    alu_sequencer #(.NREG(8), .W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_en(alu_en), .alu_setflag(alu_setflag),
        .alu_r(alu_r), .alu_z(alu_z), .alu_n(alu_n),
        .flag_z(flag_z), .flag_n(flag_n), .done(done), .busy(busy)
    );

    function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'b000:  return a + b;
            3'b111:  return a - b;
            3'b100:  return a & b;
            3'b010:  return a | b;
            3'b001:  return ~a;
            default: return 16'h0000;
        endcase
    endfunction

    always_comb begin
        alu_r = alu_ref(alu_op, alu_a, alu_b);
        alu_z = (alu_a == alu_b);
        alu_n = (alu_a < alu_b);
    end

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    function automatic logic [15:0] mk(input logic [2:0] op, input logic sf, input logic wb,
                                       input logic [2:0] d, input logic [2:0] sa, input logic [2:0] sb);
        logic [1:0] rsv;
        rsv = 2'($urandom);
        return {op, sf, wb, d, sa, sb, rsv};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_valid = 1'b0;
        m_reg[a] = d;
    endtask

    task automatic issue(input logic [15:0] ins);
        int t = 0;
        while (instr_ready !== 1'b1 && t < 10) begin tick(); t++; end
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++; $display("FAIL issue_ready_timeout got %b exp 1", instr_ready);
        end
        instr = ins; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i); #1;
            checks++;
            if (rd_data !== 16'h0000) begin errors++; $display("FAIL reset_reg%0d got %h exp 0000", i, rd_data); end
        end
        checks++;
        if ({instr_ready, alu_en, flag_z, flag_n, done, busy} !== 6'b100000) begin
            errors++; $display("FAIL reset_ctrl got rdy/en/z/n/done/busy=%b exp 100000",
                               {instr_ready, alu_en, flag_z, flag_n, done, busy});
        end
        checks++;
        if ({alu_a, alu_b, alu_op, alu_setflag} !== 36'h0) begin
            errors++; $display("FAIL reset_alu_idle got a=%h b=%h op=%b sf=%b", alu_a, alu_b, alu_op, alu_setflag);
        end
        for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
        m_z = 1'b0; m_n = 1'b0;
        rst_n = 1'b1;
        tick();
        preload(3'd1, 16'h0005);
        preload(3'd2, 16'h0003);
        rd_addr = 3'd1; #1;
        checks++;
        if (rd_data !== 16'h0005) begin errors++; $display("FAIL preload_r1 got %h exp 0005", rd_data); end
        rd_addr = 3'd2; #1;
        checks++;
        if (rd_data !== 16'h0003) begin errors++; $display("FAIL preload_r2 got %h exp 0003", rd_data); end
    endtask

    task automatic test_add();
        int d0 = done_cnt;
        issue(mk(3'b000, 1'b0, 1'b1, 3'd3, 3'd1, 3'd2));
        checks++;
        if ({alu_en, alu_a, alu_b, alu_op, instr_ready, busy, done} !== {1'b1, 16'h0005, 16'h0003, 3'b000, 3'b010}) begin
            errors++; $display("FAIL add_exec got en=%b a=%h b=%h op=%b rdy=%b busy=%b done=%b",
                               alu_en, alu_a, alu_b, alu_op, instr_ready, busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b1 || alu_en !== 1'b0) begin errors++; $display("FAIL add_wb got done=%b en=%b exp 1 0", done, alu_en); end
        tick();
        m_reg[3] = 16'h0008;
        rd_addr = 3'd3; #1;
        checks++;
        if (rd_data !== 16'h0008) begin errors++; $display("FAIL add_r3 got %h exp 0008", rd_data); end
        checks++;
        if ({flag_z, flag_n, done, instr_ready} !== {m_z, m_n, 1'b0, 1'b1} || done_cnt != d0 + 1) begin
            errors++; $display("FAIL add_after got z=%b n=%b done=%b rdy=%b pulses=%0d exp z=%b n=%b 0 1 1",
                               flag_z, flag_n, done, instr_ready, done_cnt - d0, m_z, m_n);
        end
    endtask

    task automatic test_sub_flags();
        preload(3'd1, 16'h0003);
        preload(3'd2, 16'h0005);
        issue(mk(3'b111, 1'b1, 1'b1, 3'd4, 3'd1, 3'd2));
        checks++;
        if (alu_op !== 3'b111 || alu_setflag !== 1'b1) begin
            errors++; $display("FAIL sub_exec got op=%b sf=%b exp 111 1", alu_op, alu_setflag);
        end
        tick(); tick();
        m_reg[4] = 16'hFFFE; m_z = 1'b0; m_n = 1'b1;
        rd_addr = 3'd4; #1;
        checks++;
        if (rd_data !== 16'hFFFE || flag_n !== 1'b1 || flag_z !== 1'b0) begin
            errors++; $display("FAIL sub_wrap got r4=%h z=%b n=%b exp FFFE 0 1", rd_data, flag_z, flag_n);
        end
        issue(mk(3'b111, 1'b1, 1'b0, 3'd4, 3'd1, 3'd1));
        tick(); tick();
        m_z = 1'b1; m_n = 1'b0;
        checks++;
        if (flag_z !== 1'b1 || flag_n !== 1'b0) begin
            errors++; $display("FAIL cmp_flags got z=%b n=%b exp 1 0", flag_z, flag_n);
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i); #1;
            checks++;
            if (rd_data !== m_reg[i]) begin errors++; $display("FAIL cmp_noreg r%0d got %h exp %h", i, rd_data, m_reg[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        int n = 0;
        logic [15:0] ia, ib;
        ia = mk(3'b000, 1'b0, 1'b1, 3'd6, 3'd1, 3'd2);
        ib = mk(3'b010, 1'b0, 1'b1, 3'd7, 3'd1, 3'd2);
        instr = ia; instr_valid = 1'b1;
        tick();
        checks++;
        if (alu_en !== 1'b1 || alu_op !== 3'b000 || instr_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_first got en=%b op=%b rdy=%b exp 1 000 0", alu_en, alu_op, instr_ready);
        end
        instr = ib;
        while (n < 6) begin
            tick(); n++;
            if (alu_en === 1'b1) break;
            checks++;
            if (instr_ready !== (n == 2)) begin
                errors++; $display("FAIL b2b_ready step %0d got %b exp %b", n, instr_ready, (n == 2));
            end
        end
        instr_valid = 1'b0;
        checks++;
        if (n != 3 || alu_op !== 3'b010) begin
            errors++; $display("FAIL b2b_spacing got %0d cycles op=%b exp 3 010", n, alu_op);
        end
        tick(); tick(); tick();
        m_reg[6] = m_reg[1] + m_reg[2];
        m_reg[7] = m_reg[1] | m_reg[2];
        checks++;
        if (done_cnt != d0 + 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", done_cnt - d0); end
        for (int i = 6; i < 8; i++) begin
            rd_addr = 3'(i); #1;
            checks++;
            if (rd_data !== m_reg[i]) begin errors++; $display("FAIL b2b_r%0d got %h exp %h", i, rd_data, m_reg[i]); end
        end
    endtask

    task automatic test_collision();
        logic [15:0] exp_r;
        exp_r = m_reg[1] + m_reg[2];
        issue(mk(3'b000, 1'b0, 1'b1, 3'd5, 3'd1, 3'd2));
        tick();
        ld_valid = 1'b1; ld_addr = 3'd5; ld_data = 16'hAAAA;
        tick();
        ld_valid = 1'b0;
        m_reg[5] = exp_r;
        rd_addr = 3'd5; #1;
        checks++;
        if (rd_data !== exp_r) begin errors++; $display("FAIL collision_r5 got %h exp %h", rd_data, exp_r); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            logic [15:0] ins, res, ea, eb;
            logic [2:0] op, d, sa, sb, la_e, la_w;
            logic sf, wb, ld_e, ld_w;
            logic [15:0] d_e, d_w;
            if ($urandom_range(1) == 1) preload(3'($urandom), 16'($urandom));
            op = 3'($urandom); sf = 1'($urandom); wb = 1'($urandom);
            d = 3'($urandom); sa = 3'($urandom); sb = 3'($urandom);
            ld_e = ($urandom_range(3) == 0); la_e = 3'($urandom); d_e = 16'($urandom);
            ld_w = ($urandom_range(3) == 0); la_w = 3'($urandom); d_w = 16'($urandom);
            ins = mk(op, sf, wb, d, sa, sb);
            ea = m_reg[sa]; eb = m_reg[sb];
            res = alu_ref(op, ea, eb);
            issue(ins);
            checks++;
            if ({alu_en, alu_a, alu_b, alu_op, alu_setflag} !== {1'b1, ea, eb, op, sf}) begin
                errors++; $display("FAIL rnd_exec it%0d got en=%b a=%h b=%h op=%b sf=%b exp 1 %h %h %b %b",
                                   it, alu_en, alu_a, alu_b, alu_op, alu_setflag, ea, eb, op, sf);
            end
            ld_valid = ld_e; ld_addr = la_e; ld_data = d_e;
            tick();
            checks++;
            if (done !== 1'b1) begin errors++; $display("FAIL rnd_wb_done it%0d got %b exp 1", it, done); end
            ld_valid = ld_w; ld_addr = la_w; ld_data = d_w;
            tick();
            ld_valid = 1'b0;
            if (sf) begin m_z = (ea == eb); m_n = (ea < eb); end
            if (ld_e) m_reg[la_e] = d_e;
            if (ld_w) m_reg[la_w] = d_w;
            if (wb) m_reg[d] = res;
            rd_addr = d; #1;
            checks++;
            if (rd_data !== m_reg[d] || flag_z !== m_z || flag_n !== m_n) begin
                errors++; $display("FAIL rnd_result it%0d got r%0d=%h z=%b n=%b exp %h %b %b",
                                   it, d, rd_data, flag_z, flag_n, m_reg[d], m_z, m_n);
            end
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i); #1;
            checks++;
            if (rd_data !== m_reg[i]) begin errors++; $display("FAIL rnd_final r%0d got %h exp %h", i, rd_data, m_reg[i]); end
        end
    endtask

    task automatic test_mid_reset();
        int d0;
        preload(3'd1, 16'h0003);
        preload(3'd2, 16'h0005);
        issue(mk(3'b111, 1'b1, 1'b1, 3'd6, 3'd1, 3'd2));
        d0 = done_cnt;
        rst_n = 1'b0; #1;
        checks++;
        if ({instr_ready, busy, alu_en, flag_z, flag_n} !== 5'b10000) begin
            errors++; $display("FAIL midrst_async got rdy/busy/en/z/n=%b exp 10000",
                               {instr_ready, busy, alu_en, flag_z, flag_n});
        end
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
        m_z = 1'b0; m_n = 1'b0;
        rd_addr = 3'd6; #1;
        checks++;
        if (done_cnt != d0 || rd_data !== 16'h0000 || flag_z !== 1'b0 || flag_n !== 1'b0 || instr_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_after got pulses=%0d r6=%h z=%b n=%b rdy=%b exp 0 0000 0 0 1",
                               done_cnt - d0, rd_data, flag_z, flag_n, instr_ready);
        end
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0000;
        ld_valid = 1'b0; ld_addr = 3'd0; ld_data = 16'h0000; rd_addr = 3'd0;
        test_reset();
        test_add();
        test_sub_flags();
        test_back_to_back();
        test_collision();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
